// File: rtl/board_pkg.sv
// board_pkg: shared definitions for the checkers board path.
//
// Both the board writer and the pixel renderer import this package so they
// agree on the nibble layout of the 256-bit board buffer.
//
// Contents:
//   OCC / OWNER / KING  bit positions inside a square nibble (bit3 reserved, 0)
//   INIT_BOARD          starting layout, square i at bits [4i+3:4i]
//   state_e             board_writer FSM states
//   sq_x / sq_y         column / row of a square index (idx = x + 8*y)
//   sq_base             bit offset of a square's nibble
//   sq_bit              one flag bit of a square's nibble

package board_pkg;

    localparam int unsigned OCC   = 0;
    localparam int unsigned OWNER = 1;  // 1 = red, 0 = green
    localparam int unsigned KING  = 2;

    // Red men (4'h3) on rows 0-2, green men (4'h1) on rows 5-7, playable squares only.
    // Written most-significant square (63) first, one underscore group per row.
    localparam logic [255:0] INIT_BOARD =
        256'h10101010_01010101_10101010_00000000_00000000_03030303_30303030_03030303;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StCheck,
        StApply,
        StResp
    } state_e;

    function automatic logic [2:0] sq_x(input logic [5:0] idx);
        return 3'(idx);
    endfunction

    function automatic logic [2:0] sq_y(input logic [5:0] idx);
        return 3'(idx >> 3);
    endfunction

    function automatic logic [7:0] sq_base(input logic [5:0] idx);
        return {idx, 2'b00};
    endfunction

    function automatic logic sq_bit(input logic [255:0] board, input logic [5:0] idx,
                                    input int unsigned pos);
        return board[sq_base(idx) + 8'(pos)];
    endfunction

endpackage

// File: rtl/move_checker.sv
// move_checker: combinational legality check for one checkers move.
//
// Ports:
//   board     in  256  current board buffer
//   src       in  6    source square index
//   dst       in  6    destination square index
//   red_turn  in  1    1 = red to move
//   legal     out 1    move is a legal simple move or a legal single jump
//   is_jump   out 1    geometry is a two-square diagonal step
//   mid_idx   out 6    square jumped over, (src + dst) / 2
//   promote   out 1    destination is the far row for the side to move

module move_checker
    import board_pkg::*;
(
    input  logic [255:0] board,
    input  logic [5:0]   src,
    input  logic [5:0]   dst,
    input  logic         red_turn,
    output logic         legal,
    output logic         is_jump,
    output logic [5:0]   mid_idx,
    output logic         promote
);

    logic [2:0]        src_x, src_y, dst_x, dst_y;
    logic signed [3:0] dx, dy, adx, ady;
    logic [6:0]        idx_sum;
    logic              src_occ, src_red, src_king;
    logic              dst_occ, mid_occ, mid_red;
    logic              step_one, step_two, dir_ok, base_ok, mid_opp;

    always_comb begin
        src_x = sq_x(src);
        src_y = sq_y(src);
        dst_x = sq_x(dst);
        dst_y = sq_y(dst);

        // Coordinates are 0..7, so a 4-bit signed difference covers -7..7.
        dx  = $signed({1'b0, dst_x}) - $signed({1'b0, src_x});
        dy  = $signed({1'b0, dst_y}) - $signed({1'b0, src_y});
        adx = dx[3] ? -dx : dx;
        ady = dy[3] ? -dy : dy;

        step_one = (adx == 4'sd1) && (ady == 4'sd1);
        step_two = (adx == 4'sd2) && (ady == 4'sd2);

        // Only meaningful for a two-square step, where src + dst is always even.
        idx_sum = {1'b0, src} + {1'b0, dst};
        mid_idx = 6'(idx_sum >> 1);

        src_occ  = sq_bit(board, src, OCC);
        src_red  = sq_bit(board, src, OWNER);
        src_king = sq_bit(board, src, KING);
        dst_occ  = sq_bit(board, dst, OCC);
        mid_occ  = sq_bit(board, mid_idx, OCC);
        mid_red  = sq_bit(board, mid_idx, OWNER);

        // Red men advance toward +y, green men toward -y; kings go either way.
        dir_ok  = src_king || (src_red ? (dy > 4'sd0) : (dy < 4'sd0));
        base_ok = src_occ && (src_red == red_turn) && !dst_occ && dir_ok;
        mid_opp = mid_occ && (mid_red != red_turn);

        legal   = base_ok && (step_one || (step_two && mid_opp));
        is_jump = step_two;
        promote = red_turn ? (dst_y == 3'd7) : (dst_y == 3'd0);
    end

endmodule

// File: rtl/board_writer.sv
// board_writer: sole owner of the checkers board buffer.
//
// Accepts move / new-game commands over a valid/ready handshake, checks moves
// with move_checker, applies legal moves in one edge and signals completion
// with a one-cycle done pulse.
//
// Ports:
//   clk          in  1    system clock
//   reset        in  1    synchronous, active-high
//   cmdValid     in  1    command present
//   cmdReady     out 1    command accepted this cycle if cmdValid (IDLE only)
//   cmdNewGame   in  1    reload the initial layout; src/dst ignored
//   cmdSrc       in  6    source square, x + 8*y
//   cmdDst       in  6    destination square
//   doneValid    out 1    one-cycle completion pulse
//   doneError    out 1    move rejected, board unchanged (with doneValid)
//   doneCapture  out 1    a jump removed a piece (with doneValid)
//   boardBuffer  out 256  registered board, square i at [4i+3:4i]
//   redTurn      out 1    1 = red moves next

module board_writer
    import board_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         cmdValid,
    output logic         cmdReady,
    input  logic         cmdNewGame,
    input  logic [5:0]   cmdSrc,
    input  logic [5:0]   cmdDst,
    output logic         doneValid,
    output logic         doneError,
    output logic         doneCapture,
    output logic [255:0] boardBuffer,
    output logic         redTurn
);

    state_e       state_q, state_d;
    logic [255:0] board_q, board_d;
    logic         red_turn_q, red_turn_d;
    logic [5:0]   src_q, src_d;
    logic [5:0]   dst_q, dst_d;
    logic [5:0]   mid_q, mid_d;
    logic         jump_q, jump_d;
    logic         promote_q, promote_d;
    logic         err_q, err_d;
    logic         cap_q, cap_d;

    logic         chk_legal, chk_jump, chk_promote;
    logic [5:0]   chk_mid;
    logic [2:0]   moved;

    move_checker u_move_checker (
        .board    (board_q),
        .src      (src_q),
        .dst      (dst_q),
        .red_turn (red_turn_q),
        .legal    (chk_legal),
        .is_jump  (chk_jump),
        .mid_idx  (chk_mid),
        .promote  (chk_promote)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            board_q    <= INIT_BOARD;
            red_turn_q <= 1'b1;
            src_q      <= '0;
            dst_q      <= '0;
            mid_q      <= '0;
            jump_q     <= 1'b0;
            promote_q  <= 1'b0;
            err_q      <= 1'b0;
            cap_q      <= 1'b0;
        end else begin
            board_q    <= board_d;
            red_turn_q <= red_turn_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            mid_q      <= mid_d;
            jump_q     <= jump_d;
            promote_q  <= promote_d;
            err_q      <= err_d;
            cap_q      <= cap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        red_turn_d = red_turn_q;
        src_d      = src_q;
        dst_d      = dst_q;
        mid_d      = mid_q;
        jump_d     = jump_q;
        promote_d  = promote_q;
        err_d      = err_q;
        cap_d      = cap_q;

        // Low three bits of the moving piece; the reserved bit is always rewritten as 0.
        moved = board_q[sq_base(src_q) +: 3];

        unique case (state_q)
            StIdle: begin
                if (cmdValid) begin
                    src_d   = cmdSrc;
                    dst_d   = cmdDst;
                    state_d = cmdNewGame ? StInit : StCheck;
                end
            end
            StInit: begin
                board_d    = INIT_BOARD;
                red_turn_d = 1'b1;
                err_d      = 1'b0;
                cap_d      = 1'b0;
                state_d    = StResp;
            end
            StCheck: begin
                // Keep the checker's view so APPLY does not depend on it again.
                jump_d    = chk_jump;
                mid_d     = chk_mid;
                promote_d = chk_promote;
                if (chk_legal) begin
                    state_d = StApply;
                end else begin
                    err_d   = 1'b1;
                    cap_d   = 1'b0;
                    state_d = StResp;
                end
            end
            StApply: begin
                board_d[sq_base(src_q) +: 4] = 4'h0;
                if (jump_q) begin
                    board_d[sq_base(mid_q) +: 4] = 4'h0;
                end
                board_d[sq_base(dst_q) +: 4] = {1'b0, moved[KING] | promote_q, moved[1:0]};
                red_turn_d = ~red_turn_q;
                err_d      = 1'b0;
                cap_d      = jump_q;
                state_d    = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        cmdReady    = (state_q == StIdle);
        doneValid   = (state_q == StResp);
        doneError   = doneValid & err_q;
        doneCapture = doneValid & cap_q;
        boardBuffer = board_q;
        redTurn     = red_turn_q;
    end

endmodule

// File: doc/board_writer.md
# board_writer

Board-state owner for the checkers display path. Holds the 256-bit `boardBuffer` (64 squares × 4-bit nibble) consumed by the pixel renderer, and is the only block that writes it. It accepts move and new-game commands over a valid/ready handshake, checks each move for legality, applies it over a fixed multi-cycle sequence, and reports completion with a one-cycle done pulse.

## Interface
- Parameters: none; all constants live in `board_pkg`.
- `clk` input 1 — system clock.
- `reset` input 1 — synchronous, active-high.
- `cmdValid` input 1 — command present.
- `cmdReady` output 1 — block can accept a command; high only in IDLE.
- `cmdNewGame` input 1 — with handshake, reload the initial layout and ignore `cmdSrc`/`cmdDst`.
- `cmdSrc` input 6 — source square index, `x + 8*y`.
- `cmdDst` input 6 — destination square index.
- `doneValid` output 1 — one-cycle completion pulse.
- `doneError` output 1 — valid with `doneValid`; 1 means the move was rejected and the board is unchanged.
- `doneCapture` output 1 — valid with `doneValid`; 1 means a jump removed a piece.
- `boardBuffer` output 256 — registered board state; square i occupies bits `[4i+3:4i]`.
- `redTurn` output 1 — 1 means red moves next.

## Operation
- Nibble format:
  - bit0: occupied.
  - bit1: owner (1 red, 0 green).
  - bit2: king.
  - bit3: reserved; always written 0.
- Square index decoding: x = idx[2:0], y = idx[5:3].
- Playable squares have (x+y) even.
- Initial layout:
  - Red (nibble 4'h3) on playable squares of rows 0–2: 0,2,4,6,9,11,13,15,16,18,20,22.
  - Green (4'h1) on playable squares of rows 5–7: 41,43,45,47,48,50,52,54,57,59,61,63.
  - All other nibbles are 0.
  - `redTurn` = 1.
- Movement direction: red men move toward +y; green men toward −y; kings move either way.
- Geometry: dx = dstX − srcX and dy = dstY − srcY, each 4-bit signed, computed with explicit sign extension.
- Legal simple move, all of:
  - src occupied;
  - src owner matches turn;
  - dst empty;
  - |dx| = |dy| = 1;
  - dy has the forward sign, or the piece is a king.
- Legal jump: the same conditions with |dx| = |dy| = 2, plus the mid square ((src+dst)/2) holds an opponent piece.
- Any other command is illegal, including src = dst.
- No forced-jump or multi-jump enforcement; a multi-jump is issued as successive commands.
- States:
  - IDLE: `cmdReady` = 1. On handshake, latch src/dst/newGame. Go to INIT if newGame, else CHECK.
  - INIT: load the initial layout, set `redTurn` = 1, go to RESP with error = 0, capture = 0.
  - CHECK: evaluate legality against the current buffer. Legal → APPLY; illegal → RESP with error = 1.
  - APPLY: all in one edge:
    - src nibble ← 0;
    - dst nibble ← src nibble, with bit2 set if dst reaches y = 7 (red) or y = 0 (green);
    - on a jump, mid nibble ← 0;
    - toggle `redTurn`;
    - go to RESP with error = 0 and capture = jump.
  - RESP: `doneValid` = 1 for this cycle only, then IDLE.
- Illegal commands never modify `boardBuffer` or `redTurn`.

## Timing
- Reset values:
  - `boardBuffer` = initial layout;
  - `redTurn` = 1;
  - state = IDLE;
  - `cmdReady` = 1;
  - `doneValid`, `doneError`, `doneCapture` = 0.
- Move latency: handshake at edge N. CHECK during cycle N+1, APPLY at edge N+2, `doneValid` high during cycle N+3. `boardBuffer` already shows the new state when `doneValid` rises.
- Illegal-move latency: `doneValid` high during cycle N+2.
- New-game latency: buffer reloaded at edge N+1; `doneValid` high during cycle N+2.
- `cmdReady` drops the cycle after a handshake and returns in the cycle after RESP. Back-to-back command throughput is therefore one per 4 cycles for moves and one per 3 cycles for rejects and new-game.
- `doneError` and `doneCapture` are 0 whenever `doneValid` = 0.
- `reset` mid-operation (any state): the next edge restores all reset values. The in-flight command is dropped and no `doneValid` is produced.
- `cmdValid` with `cmdReady` = 0 is ignored; the command is not queued.
- `boardBuffer` is a pure register output with no combinational path from the inputs.

## Structure
- `board_pkg` contains:
  - nibble bit positions (OCC, OWNER, KING);
  - the 256-bit `INIT_BOARD` constant;
  - the state enum;
  - the square-index helper functions for x, y and nibble select.
- The renderer shares `board_pkg` so both ends agree on the nibble format.
- Sub-module `move_checker`: purely combinational. Inputs: buffer, src, dst, `redTurn`. Outputs: `legal`, `isJump`, `midIdx`, `promote`. It is instantiated once and used in CHECK; APPLY reuses its registered results.

## Test plan
- Reset → `boardBuffer[3:0]` = 4'h3, `[7:4]` = 4'h0, `[167:164]` (sq 41) = 4'h1, `cmdReady` = 1, `redTurn` = 1.
- Move 18→27 on the initial board → `doneValid` 3 cycles after the handshake with error = 0 and capture = 0. Then sq 18 = 0, sq 27 = 4'h3, `redTurn` = 0.
- Next, with green to move, command 27→36 → `doneValid` 2 cycles after the handshake, error = 1, buffer and `redTurn` unchanged.
- Green jump:
  - Sequence 18→27, 45→36, 22→29, then 36→18.
  - 36→18 reports capture = 1.
  - Result: sq 27 = 0, sq 18 = 4'h1, sq 36 = 0.
- Promotion: preload a red man on sq 54 with sq 63 empty and red to move, move 54→63 → sq 63 = 4'h7. A subsequent king move toward −y is accepted.
- `reset` asserted during CHECK or APPLY of a legal move → no `doneValid`, buffer equals `INIT_BOARD` after one edge. `cmdNewGame` after moves → `INIT_BOARD`, `redTurn` = 1, `doneValid` 2 cycles after the handshake.
